spi_slave_stream: RTL and testbench
===================================

// Module: spi_slave_stream
// PURPOSE
// - Parametrised SPI slave with a word-stream interface: configurable word width, CPOL/CPHA mode and bit order.
// - Full-duplex: transmits TX words and receives RX words over valid/ready handshakes, with overrun/underrun flags.
// - Sits between the external MCU SPI master and FPGA-side register/stream logic; one slave on the bus.
// PARAMETERS
// - DATA_W        8  bits per SPI word (2..32)
// - CPOL          0  SCK idle level
// - CPHA          0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
// - MSB_FIRST     1  1: MSB first on both MOSI and MISO; 0: LSB first
// - RX_FIFO_DEPTH 4  RX FIFO entries, power of 2; used only with SPI_RX_FIFO_EN
// PORTS
// - clk          in   1       system clock; must be >= 8x SCK frequency
// - rst          in   1       synchronous reset, active high
// - sck          in   1       SPI clock (async)
// - ssel         in   1       slave select, active low (async)
// - mosi         in   1       master out (async)
// - miso         out  1       slave out
// - miso_oe      out  1       high while the frame is active (external tristate)
// - tx_data      in   DATA_W  next word to transmit
// - tx_valid     in   1       tx_data valid
// - tx_ready     out  1       1-cycle pulse: tx_data consumed this cycle
// - rx_data      out  DATA_W  received word
// - rx_valid     out  1       rx_data valid; held until rx_ready
// - rx_ready     in   1       consumer accepts rx_data
// - busy         out  1       frame active (synchronised ssel low and armed)
// - rx_overrun   out  1       1-cycle pulse: received word lost or overwritten
// - tx_underrun  out  1       1-cycle pulse: word load with tx_valid low; zeros sent
// BEHAVIOUR
// - Sync: sck and ssel use 3-flop sync plus edge detect; mosi uses 2 flops aligned to the sck edge decision.
// - Sample edge = rising if CPOL^CPHA==0, else falling; shift edge = the opposite edge.
// - Reset: miso=0, miso_oe=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, pulses=0; bit counter=0.
// - Reset loads the sync flops with idle levels (ssel=1, sck=CPOL). The block stays disarmed until synchronised ssel is seen high.
// - Frame start (armed, ssel 1->0): load word 0 from tx_data if tx_valid and pulse tx_ready; else load 0 and pulse tx_underrun.
// - CPHA=0: bit 0 of the word drives miso from frame start. CPHA=1: bit 0 drives miso from the first leading edge.
// - Each sample edge: shift mosi into the RX shift register and increment bit counter (0..DATA_W-1, wraps).
// - Sample edge of bit DATA_W-1: RX word complete. Next TX word loaded then (same tx_valid/underrun rule) and presented from the next shift edge.
// - RX completion, no FIFO: rx_data/rx_valid update the next clk.
//   - If rx_valid is already high and rx_ready is low that cycle, the new word overwrites and rx_overrun pulses.
//   - rx_ready and completion in the same cycle: the new word is taken, no overrun.
// - ssel deassert mid-word: partial RX bits discarded (no rx_valid); preloaded TX word discarded; counter reset; miso_oe=0 next cycle.
// - busy/miso_oe are asserted from the cycle after start is detected until the cycle after end is detected.
// - rst mid-frame: all state cleared; the remainder of the frame is ignored until ssel goes high again (re-arm).
// - Latency: ssel/sck pin edge to internal action 3 clk; RX word completion to rx_valid 1 clk after the internal sample edge.
// CONFIGURATION
// - SPI_RX_FIFO_EN defined: completed words are pushed into an RX_FIFO_DEPTH FIFO.
//   - rx_valid = FIFO not empty; rx_data = head; pop on rx_valid&&rx_ready.
//   - Full: new word dropped, FIFO contents kept, rx_overrun pulses.
//   - Push and pop in the same cycle when full: accepted, no overrun.
// - Undefined: single output register with overwrite semantics as above.
// TESTING
// - Mode 0, DATA_W=8: tx_data=0xA5 valid; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one tx_ready pulse.
// - Mode 3, MSB_FIRST=0: 2-word frame, tx 0x81 then 0x7E -> rx words match MOSI LSB-first; miso correct on every sample edge.
// - tx_valid low at frame start -> miso all 0; tx_underrun pulses once; rx still delivered.
// - rx_ready held low, 3 words -> no FIFO: rx_data = word 3, 2 overrun pulses. With SPI_RX_FIFO_EN (depth 4): all 3 words kept, 0 overruns.
// - ssel released after 5 bits -> no rx_valid; next full frame decodes correctly.
// - rst asserted mid-word with ssel held low -> no rx_valid or tx_ready until ssel goes high and a new frame completes.

Source files
------------

// File: rtl/spi_slave_stream.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_stream
// Summary  : SPI slave with word-stream TX/RX handshakes. Configurable word
//            width, CPOL/CPHA mode and bit order. Full duplex, with
//            overrun/underrun pulses.
// Option   : define SPI_RX_FIFO_EN to queue received words in an
//            RX_FIFO_DEPTH-entry FIFO instead of a single overwrite register.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_stream #(
    parameter int DATA_W        = 8,
    parameter int CPOL          = 0,
    parameter int CPHA          = 0,
    parameter int MSB_FIRST     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ssel,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              rx_overrun,
    output logic              tx_underrun
);

    localparam int          CNT_W       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic        SCK_IDLE    = (CPOL != 0);
    localparam logic        SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    logic [2:0]        sck_sync;
    logic [2:0]        ssel_sync;
    logic [1:0]        mosi_sync;
    logic [1:0]        settle;
    state_t            state;
    state_t            state_nx;
    logic              frame_start;
    logic              frame_end;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] tx_hold;
    logic [DATA_W-1:0] load_word;
    logic              tx_pend;
    logic              tx_bit;

    // Reset puts the synchronisers at idle levels; settle marks when the
    // pipeline holds real pin samples rather than those reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= {3{SCK_IDLE}};
            ssel_sync <= 3'b111;
            mosi_sync <= 2'b00;
            settle    <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            ssel_sync <= {ssel_sync[1:0], ssel};
            mosi_sync <= {mosi_sync[0], mosi};
            settle    <= {settle[0], 1'b1};
        end
    end

    wire ssel_high   = ssel_sync[1];
    wire ssel_fall   = ssel_sync[2] & ~ssel_sync[1];
    wire sck_rise    = sck_sync[1] & ~sck_sync[2];
    wire sck_fall    = ~sck_sync[1] & sck_sync[2];
    wire mosi_bit    = mosi_sync[1];
    wire in_frame    = (state == ST_ACTIVE) & ~ssel_high;
    wire sample_edge = in_frame & (SAMPLE_RISE ? sck_rise : sck_fall);
    wire shift_edge  = in_frame & (SAMPLE_RISE ? sck_fall : sck_rise);
    wire word_done   = sample_edge & (bit_cnt == LAST_BIT);
    wire tx_load     = frame_start | word_done;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_DISARMED;
        else     state <= state_nx;
    end

    // Arm only after a genuine high ssel, then track frame start/end.
    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_DISARMED: if (settle[1] && ssel_high) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (ssel_fall) begin
                    state_nx    = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ssel_high) begin
                    state_nx  = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nx = ST_DISARMED;
        endcase
    end

    // Bit order only changes which end of the shift registers is used.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign rx_next    = {rx_sh[DATA_W-2:0], mosi_bit};
            assign tx_shifted = {tx_sh[DATA_W-2:0], 1'b0};
            assign tx_bit     = tx_sh[DATA_W-1];
        end else begin : g_lsb_first
            assign rx_next    = {mosi_bit, rx_sh[DATA_W-1:1]};
            assign tx_shifted = {1'b0, tx_sh[DATA_W-1:1]};
            assign tx_bit     = tx_sh[0];
        end
    endgenerate

    assign load_word   = tx_valid ? tx_data : '0;
    assign tx_ready    = tx_load & tx_valid & ~rst;
    assign tx_underrun = tx_load & ~tx_valid & ~rst;
    assign busy        = (state == ST_ACTIVE);
    assign miso_oe     = busy;
    assign miso        = busy & tx_bit;

    // TX path: a loaded word waits in tx_hold until the next shift edge,
    // except the first word in CPHA=0 which must be on miso immediately.
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            tx_sh   <= '0;
            tx_hold <= '0;
            tx_pend <= 1'b0;
        end else if (frame_start) begin
            if (CPHA == 0) begin
                tx_sh <= load_word;
            end else begin
                tx_hold <= load_word;
                tx_pend <= 1'b1;
            end
        end else begin
            if (word_done) begin
                tx_hold <= load_word;
                tx_pend <= 1'b1;
            end
            if (shift_edge) begin
                if (tx_pend) begin
                    tx_sh   <= tx_hold;
                    tx_pend <= 1'b0;
                end else begin
                    tx_sh <= tx_shifted;
                end
            end
        end
    end

    // RX shift register and bit counter; partial words die with the frame.
    always_ff @(posedge clk) begin
        if (rst || frame_end || frame_start) begin
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else if (sample_edge) begin
            rx_sh   <= rx_next;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    wire fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wire fifo_pop  = rx_valid & rx_ready;
    wire fifo_push = word_done & (~fifo_full | fifo_pop);

    assign rx_valid = (wr_ptr != rd_ptr);
    assign rx_data  = fifo_mem[rd_ptr[AW-1:0]];

    // RX FIFO: a push into a full FIFO is accepted only alongside a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            rx_overrun <= word_done & fifo_full & ~fifo_pop;
            if (fifo_push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= rx_next;
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    // Single output register: a new word always wins; losing an unread one
    // raises the overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_stream
// Summary  : Self-checking bench: SPI master model driving a mode-0 MSB-first
//            slave and a mode-3 LSB-first slave, 8-bit words.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_stream;

    localparam int H = 80;   // SCK half period in ns (clk period 10 ns)

    logic       clk = 1'b0;
    logic       rst;
    logic       mosi;
    logic       sck0, ssel0, sck3, ssel3;
    logic [7:0] tx_data0, tx_data3;
    logic       tx_valid0, tx_valid3, rx_ready0, rx_ready3;
    logic       miso0, miso_oe0, tx_ready0, rx_valid0, busy0, rx_overrun0, tx_underrun0;
    logic       miso3, miso_oe3, tx_ready3, rx_valid3, busy3, rx_overrun3, tx_underrun3;
    logic [7:0] rx_data0, rx_data3;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_txr0 = 0, cnt_und0 = 0, cnt_ovr0 = 0;
    int cnt_txr3 = 0, cnt_und3 = 0, cnt_ovr3 = 0;
    logic [7:0] rxq0[$];
    logic [7:0] rxq3[$];
    int rd0 = 0, rd3 = 0;

    always #5 clk = ~clk;

    spi_slave_stream #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .RX_FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .sck(sck0), .ssel(ssel0), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .busy(busy0), .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0)
    );

    spi_slave_stream #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .RX_FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .sck(sck3), .ssel(ssel3), .mosi(mosi),
        .miso(miso3), .miso_oe(miso_oe3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
        .busy(busy3), .rx_overrun(rx_overrun3), .tx_underrun(tx_underrun3)
    );

    // Pulse counters and accepted-word log, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_ready0)    cnt_txr0++;
        if (tx_underrun0) cnt_und0++;
        if (rx_overrun0)  cnt_ovr0++;
        if (tx_ready3)    cnt_txr3++;
        if (tx_underrun3) cnt_und3++;
        if (rx_overrun3)  cnt_ovr3++;
        if (rx_valid0 && rx_ready0) rxq0.push_back(rx_data0);
        if (rx_valid3 && rx_ready3) rxq3.push_back(rx_data3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int w, input logic v);
        if (w == 0) ssel0 = v; else ssel3 = v;
    endtask

    task automatic set_tx(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin tx_data0 = d; tx_valid0 = v; end
        else        begin tx_data3 = d; tx_valid3 = v; end
    endtask

    // One bit as an SPI master; m is miso as seen at the sample edge.
    task automatic xfer_bit(input int w, input logic b, output logic m);
        if (w == 0) begin
            mosi = b; #H; sck0 = 1'b1; m = miso0; #H; sck0 = 1'b0;
        end else begin
            sck3 = 1'b0; mosi = b; #H; sck3 = 1'b1; m = miso3; #H;
        end
    endtask

    task automatic frame_begin(input int w);
        set_sel(w, 1'b0);
        if (w != 0) #H;
    endtask

    task automatic frame_end(input int w);
        #H; set_sel(w, 1'b1); #(2*H);
    endtask

    // Full master frame. Load j of the TX stream (start, then each word end)
    // sees tw[j]/tv[j]; an unloaded word is transmitted as zeros.
    task automatic do_frame(input int w, input int nbits, input logic [7:0] mw[4],
                            input logic [7:0] tw[5], input logic tv[5], input string tag);
        int   b_r, b_u, nl, er, k, bi;
        logic m, expb;
        b_r = (w == 0) ? cnt_txr0 : cnt_txr3;
        b_u = (w == 0) ? cnt_und0 : cnt_und3;
        set_tx(w, tw[0], tv[0]);
        frame_begin(w);
        for (int i = 0; i < nbits; i++) begin
            k  = i / 8;
            bi = (w == 0) ? 7 - (i % 8) : (i % 8);
            xfer_bit(w, mw[k][bi], m);
            expb = tv[k] ? tw[k][bi] : 1'b0;
            chk($sformatf("%s miso bit %0d", tag, i), m, expb);
            if (i % 8 == 0) set_tx(w, tw[k+1], tv[k+1]);
            if (i == 0) begin
                chk({tag, " busy"},    (w == 0) ? busy0 : busy3, 1);
                chk({tag, " miso_oe"}, (w == 0) ? miso_oe0 : miso_oe3, 1);
            end
        end
        frame_end(w);
        nl = 1 + nbits / 8;
        er = 0;
        for (int j = 0; j < nl; j++) er += int'(tv[j]);
        chk({tag, " tx_ready count"},    ((w == 0) ? cnt_txr0 : cnt_txr3) - b_r, er);
        chk({tag, " tx_underrun count"}, ((w == 0) ? cnt_und0 : cnt_und3) - b_u, nl - er);
        chk({tag, " busy idle"},         (w == 0) ? busy0 : busy3, 0);
        chk({tag, " miso_oe idle"},      (w == 0) ? miso_oe0 : miso_oe3, 0);
    endtask

    // Next word accepted at the stream output must equal exp.
    task automatic chk_rx(input int w, input logic [7:0] exp, input string tag);
        int sz;
        sz = (w == 0) ? rxq0.size() : rxq3.size();
        chk({tag, " rx word present"}, (sz > ((w == 0) ? rd0 : rd3)) ? 1 : 0, 1);
        if (w == 0 && sz > rd0) begin chk({tag, " rx word"}, rxq0[rd0], exp); rd0++; end
        if (w != 0 && sz > rd3) begin chk({tag, " rx word"}, rxq3[rd3], exp); rd3++; end
    endtask

    initial begin
        logic [7:0] mw[4];
        logic [7:0] tw[5];
        logic       tv[5];
        logic       m;
        int         b_r, b_q, b_o;

        rst = 1'b1; mosi = 1'b0;
        sck0 = 1'b0; ssel0 = 1'b1; sck3 = 1'b1; ssel3 = 1'b1;
        tx_data0 = '0; tx_valid0 = 1'b0; tx_data3 = '0; tx_valid3 = 1'b0;
        rx_ready0 = 1'b1; rx_ready3 = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #100;

        // Reset state
        chk("reset miso",        miso0, 0);
        chk("reset miso_oe",     miso_oe0, 0);
        chk("reset busy",        busy0, 0);
        chk("reset rx_valid",    rx_valid0, 0);
        chk("reset rx_data",     rx_data0, 0);
        chk("reset tx_ready",    tx_ready0, 0);
        chk("reset tx_underrun", tx_underrun0, 0);
        chk("reset rx_overrun",  rx_overrun0, 0);
        chk("reset busy m3",     busy3, 0);
        chk("reset miso m3",     miso3, 0);

        // Mode 0: send 0xA5 while master sends 0x3C
        mw = '{8'h3C, 8'h00, 8'h00, 8'h00};
        tw = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        tv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_frame(0, 8, mw, tw, tv, "m0 basic");
        chk_rx(0, 8'h3C, "m0 basic");

        // Mode 3 LSB first: two-word frame, 0x81 then 0x7E
        mw = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
        tw = '{8'h81, 8'h7E, 8'h00, 8'h00, 8'h00};
        tv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_frame(1, 16, mw, tw, tv, "m3 two-word");
        chk_rx(1, mw[0], "m3 word0");
        chk_rx(1, mw[1], "m3 word1");

        // Underrun at frame start: zeros transmitted, RX still delivered
        mw = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        tw = '{8'hFF, 8'($urandom), 8'h00, 8'h00, 8'h00};
        tv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_frame(0, 8, mw, tw, tv, "m0 underrun");
        chk_rx(0, mw[0], "m0 underrun");

        // rx_ready held low across three words
        rx_ready0 = 1'b0;
        b_o = cnt_ovr0;
        for (int i = 0; i < 3; i++) mw[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin tw[i] = 8'($urandom); tv[i] = 1'b1; end
        do_frame(0, 24, mw, tw, tv, "m0 backpressure");
        chk("bp rx_valid", rx_valid0, 1);
`ifdef SPI_RX_FIFO_EN
        chk("bp overruns", cnt_ovr0 - b_o, 0);
        chk("bp head", rx_data0, mw[0]);
`else
        chk("bp overruns", cnt_ovr0 - b_o, 2);
        chk("bp rx_data", rx_data0, mw[2]);
`endif
        rx_ready0 = 1'b1;
        #100;
`ifdef SPI_RX_FIFO_EN
        chk_rx(0, mw[0], "bp fifo0");
        chk_rx(0, mw[1], "bp fifo1");
`endif
        chk_rx(0, mw[2], "bp last");
        chk("bp drained", rx_valid0, 0);

        // ssel released after 5 bits, then a clean frame
        b_q = rxq0.size();
        mw = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        tw = '{8'($urandom), 8'($urandom), 8'h00, 8'h00, 8'h00};
        tv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_frame(0, 5, mw, tw, tv, "m0 abort");
        chk("abort no rx", rxq0.size() - b_q, 0);
        chk("abort rx_valid", rx_valid0, 0);
        mw[0] = 8'($urandom);
        tw[0] = 8'($urandom);
        do_frame(0, 8, mw, tw, tv, "m0 after abort");
        chk_rx(0, mw[0], "m0 after abort");

        // rst mid-word with ssel held low: remainder of frame ignored
        set_tx(0, 8'($urandom), 1'b1);
        frame_begin(0);
        for (int i = 0; i < 3; i++) xfer_bit(0, 1'($urandom), m);
        rst = 1'b1; #20; rst = 1'b0;
        b_r = cnt_txr0;
        b_q = rxq0.size();
        for (int i = 0; i < 13; i++) xfer_bit(0, 1'($urandom), m);
        chk("rst mid busy",    busy0, 0);
        chk("rst mid miso_oe", miso_oe0, 0);
        frame_end(0);
        chk("rst mid tx_ready", cnt_txr0 - b_r, 0);
        chk("rst mid no rx",    rxq0.size() - b_q, 0);
        chk("rst mid rx_valid", rx_valid0, 0);
        mw[0] = 8'($urandom);
        tw[0] = 8'($urandom);
        do_frame(0, 8, mw, tw, tv, "m0 after rst");
        chk_rx(0, mw[0], "m0 after rst");

        // Random frames on both modes
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 2; i++) mw[i] = 8'($urandom);
            for (int i = 0; i < 3; i++) begin tw[i] = 8'($urandom); tv[i] = 1'($urandom); end
            do_frame(f % 2, 16, mw, tw, tv, $sformatf("rand%0d", f));
            chk_rx(f % 2, mw[0], "rand w0");
            chk_rx(f % 2, mw[1], "rand w1");
        end
        chk("m3 overruns", cnt_ovr3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
